prio_encoder_rr: RTL

Parametrised N-to-log2(N) priority encoder with a registered output and valid/ready handshake.
- Replaces fixed 4x2 combinational encoders wherever request vectors need arbitration.
- Two run-time modes: fixed priority (highest index wins) and round-robin (rotating priority pointer).
- Sits between request sources and a single downstream consumer; one encoded index per accepted transfer.

---
 rtl/prio_encoder_rr.sv | 106 ++++++++++
 1 files changed

// File: rtl/prio_encoder_rr.sv
// Purpose: N-to-log2(N) priority encoder, fixed (highest index) or round-robin, registered result.
// Latency: 1 clk from sampled req to idx/grant/multi; zero-bubble with out_ready held high.
// Backpressure: while out_valid && !out_ready everything holds and req is ignored.
// Optional: define PENC_MULTI_CNT_EN to add the saturating multi_cnt[15:0] output.
module prio_encoder_rr #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] idx,
   output logic [N-1:0] grant,
   output logic         multi
`ifdef PENC_MULTI_CNT_EN
   ,
   output logic [15:0]  multi_cnt
`endif
);

   // N expressed in W+1 bits so pointer arithmetic compares at matching width
   localparam logic [W:0] N_L = (W+1)'(N);

   logic [W-1:0] ptr;
   logic         load;
   logic         req_any;
   logic         multi_nxt;
   logic [W-1:0] fx_win;
   logic [W-1:0] rr_win;
   logic [W-1:0] win;
   logic [N-1:0] grant_nxt;
   logic [W:0]   win_inc;
   logic [W-1:0] ptr_nxt;

   assign load      = !out_valid || out_ready;
   assign req_any   = |req;
   assign multi_nxt = (req & (req - 1'b1)) != '0;

   // fixed priority: the last set bit seen while scanning upward is the highest index
   always_comb begin
      fx_win = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) fx_win = W'(i);
      end
   end

   // round-robin: first set bit scanning ptr, ptr+1, ... wrapping at N
   always_comb begin
      logic       found;
      logic [W:0] pos;
      found  = 1'b0;
      rr_win = '0;
      pos    = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (W+1)'(k);
         if (pos >= N_L) pos = pos - N_L;
         if (!found && req[pos[W-1:0]]) begin
            found  = 1'b1;
            rr_win = pos[W-1:0];
         end
      end
   end

   // select winner, build its one-hot and the pointer that follows it (N-1 wraps to 0)
   always_comb begin
      win       = mode ? rr_win : fx_win;
      grant_nxt = '0;
      grant_nxt[win] = 1'b1;
      win_inc   = {1'b0, win} + 1'b1;
      ptr_nxt   = (win_inc == N_L) ? '0 : win_inc[W-1:0];
   end

   // result registers and RR pointer; an empty request only drops out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         idx       <= '0;
         grant     <= '0;
         multi     <= 1'b0;
         ptr       <= '0;
      end else if (load) begin
         out_valid <= req_any;
         if (req_any) begin
            idx   <= win;
            grant <= grant_nxt;
            multi <= multi_nxt;
            if (mode) ptr <= ptr_nxt;
         end
      end
   end

`ifdef PENC_MULTI_CNT_EN
   // count loads that saw more than one request, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         multi_cnt <= '0;
      end else if (load && req_any && multi_nxt && multi_cnt != 16'hFFFF) begin
         multi_cnt <= multi_cnt + 16'd1;
      end
   end
`endif

endmodule
